// File: rtl/filter_package.sv
`default_nettype none
// ============================================================================
// Module   : filter_package
// Purpose  : Shared constants and state encoding for the receiver-filter
//            setting controller and its helpers.
// Revision : 1.0 - initial release
// ============================================================================
package filter_package;

   localparam int NUM_UI           = 8;   // filter input history depth
   localparam int RX_SETTING_WIDTH = 4;   // setting index width
   localparam int NUM_RX_SETTINGS  = 12;  // indices >= this are illegal
   localparam int PWL_LATENCY      = 2;   // rx_setting -> settled PWL outputs
   localparam int DEFAULT_SETTING  = 0;   // rx_setting after reset
   localparam int HIST_COUNT_WIDTH = $clog2(NUM_UI + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STALL   = 3'd1,
      ST_APPLY   = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_RELEASE = 3'd4
   } FILTER_CTRL_STATE;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with enable that saturates at MAX.
// Ports    : clk     - clock
//            rst     - asynchronous active-low reset (clears count)
//            i_en    - count enable, one increment per enabled cycle
//            o_count - registered count, holds at MAX
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_count <= '0;
      end else if (i_en && (o_count != c_max)) begin
         o_count <= o_count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/filter_setting_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : filter_setting_ctrl
// Purpose  : Owns the receiver-filter setting bus. A host update is applied
//            by freezing emulated time (stall handshake with the time
//            manager), switching rx_setting, waiting out the PWL table
//            latency and then releasing time. Also tracks how full the
//            filter input history is and qualifies the filter output.
// Ports    : clk, rst (async active-low)
//            time_eq_in              - filter input event strobe
//            upd_valid/upd_setting   - host update request
//            upd_ready               - update accepted this cycle
//            stall_req/stall_ack     - time-freeze handshake
//            rx_setting              - setting bus to PWL blocks
//            hist_count              - valid history entries (saturating)
//            out_valid               - filter output qualified
//            upd_done                - pulse when an update is applied
//            err_illegal/err_event   - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module filter_setting_ctrl #(
   parameter int NUM_UI           = filter_package::NUM_UI,
   parameter int RX_SETTING_WIDTH = filter_package::RX_SETTING_WIDTH,
   parameter int NUM_RX_SETTINGS  = filter_package::NUM_RX_SETTINGS,
   parameter int PWL_LATENCY      = filter_package::PWL_LATENCY,
   parameter int DEFAULT_SETTING  = filter_package::DEFAULT_SETTING
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          time_eq_in,
   input  logic                          upd_valid,
   input  logic [RX_SETTING_WIDTH-1:0]   upd_setting,
   output logic                          upd_ready,
   output logic                          stall_req,
   input  logic                          stall_ack,
   output logic [RX_SETTING_WIDTH-1:0]   rx_setting,
   output logic [$clog2(NUM_UI+1)-1:0]   hist_count,
   output logic                          out_valid,
   output logic                          upd_done,
   output logic                          err_illegal,
   output logic                          err_event
);

   import filter_package::*;

   localparam int c_hist_w   = $clog2(NUM_UI + 1);
   localparam int c_settle_w = (PWL_LATENCY > 1) ? $clog2(PWL_LATENCY) : 1;

   localparam logic [c_hist_w-1:0]         c_hist_full   = c_hist_w'(NUM_UI);
   localparam logic [c_settle_w-1:0]       c_settle_load = c_settle_w'(PWL_LATENCY - 1);
   localparam logic [RX_SETTING_WIDTH-1:0] c_default     = RX_SETTING_WIDTH'(DEFAULT_SETTING);
   // One extra bit so the legal-range limit is representable even when it
   // equals 2**RX_SETTING_WIDTH.
   localparam logic [RX_SETTING_WIDTH:0]   c_num_settings = (RX_SETTING_WIDTH+1)'(NUM_RX_SETTINGS);

   FILTER_CTRL_STATE                r_state;
   logic [RX_SETTING_WIDTH-1:0]     r_pending;
   logic [c_settle_w-1:0]           r_settle_cnt;

   logic                            w_illegal;
   logic                            w_same;

   assign w_illegal = ({1'b0, upd_setting} >= c_num_settings);
   assign w_same    = (upd_setting == rx_setting);

   // History fill level: setting changes keep the history, only the pulse
   // tables change, so nothing but reset clears this count.
   sat_counter #(
      .WIDTH (c_hist_w),
      .MAX   (NUM_UI)
   ) u_hist_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_en    (time_eq_in),
      .o_count (hist_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_pending    <= c_default;
         r_settle_cnt <= '0;
         rx_setting   <= c_default;
         upd_ready    <= 1'b0;
         stall_req    <= 1'b0;
         upd_done     <= 1'b0;
         out_valid    <= 1'b0;
         err_illegal  <= 1'b0;
         err_event    <= 1'b0;
      end else begin
         upd_done  <= 1'b0;
         out_valid <= (hist_count == c_hist_full) && (r_state == ST_IDLE);

         // An input event while time is frozen means the history moved under
         // a changing setting; it is still counted but flagged.
         if (time_eq_in && stall_ack) begin
            err_event <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               upd_ready <= 1'b1;
               if (upd_valid && upd_ready) begin
                  if (w_illegal) begin
                     err_illegal <= 1'b1;
                  end else if (w_same) begin
                     upd_done <= 1'b1;
                  end else begin
                     r_pending <= upd_setting;
                     r_state   <= ST_STALL;
                     upd_ready <= 1'b0;
                     stall_req <= 1'b1;
                  end
               end
            end

            ST_STALL: begin
               if (stall_ack) begin
                  rx_setting <= r_pending;
                  r_state    <= ST_APPLY;
               end
            end

            ST_APPLY: begin
               if (!stall_ack) begin
                  err_event <= 1'b1;
               end
               r_settle_cnt <= c_settle_load;
               r_state      <= ST_SETTLE;
            end

            // Time must stay frozen while the tables settle; a dropped ack
            // is flagged but the sequence still completes.
            ST_SETTLE: begin
               if (!stall_ack) begin
                  err_event <= 1'b1;
               end
               if (r_settle_cnt == '0) begin
                  r_state   <= ST_RELEASE;
                  stall_req <= 1'b0;
                  upd_done  <= 1'b1;
               end else begin
                  r_settle_cnt <= r_settle_cnt - 1'b1;
               end
            end

            ST_RELEASE: begin
               if (!stall_ack) begin
                  r_state   <= ST_IDLE;
                  upd_ready <= 1'b1;
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               stall_req <= 1'b0;
               upd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/filter_setting_ctrl.md
Name: filter_setting_ctrl

Overview:
- Controller that owns the receiver-filter setting bus and applies host-requested setting changes safely.
- Freezes emulated time via stall handshake with the time manager, switches `rx_setting`, waits out the PWL table pipeline latency, then releases time.
- Tracks how many time events have filled the filter input history; qualifies the filter output as valid only when history is full and no setting change is in flight.
- Sits between the host/config interface, the time manager, and the filter datapath.

Parameters:
- NUM_UI, 8, depth of filter input history (number of UI terms).
- RX_SETTING_WIDTH, 4, width of setting index.
- NUM_RX_SETTINGS, 12, number of legal settings; indices >= this are illegal.
- PWL_LATENCY, 2, clk cycles from `rx_setting` change to settled PWL step outputs.
- DEFAULT_SETTING, 0, `rx_setting` value after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- time_eq_in  in  1  filter input event strobe (same strobe that loads the filter history).
- upd_valid  in  1  host setting-update request valid.
- upd_setting  in  RX_SETTING_WIDTH  requested setting index.
- upd_ready  out  1  controller accepts an update this cycle.
- stall_req  out  1  request to time manager to freeze time advance.
- stall_ack  in  1  time manager confirms time frozen (level, held while frozen).
- rx_setting  out  RX_SETTING_WIDTH  setting bus to filter PWL blocks.
- hist_count  out  $clog2(NUM_UI+1)  number of valid history entries, saturating.
- out_valid  out  1  filter output qualified.
- upd_done  out  1  one-cycle pulse when an accepted update is fully applied.
- err_illegal  out  1  sticky: illegal setting requested.
- err_event  out  1  sticky: time_eq_in seen while stall_ack high.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rx_setting=DEFAULT_SETTING, hist_count=0.
  - stall_req, upd_done, out_valid, err_illegal, err_event all 0.
  - upd_ready reflects IDLE, i.e. 1 one cycle after reset release (registered).
- All outputs are registered.

- FSM states:
  - IDLE:
    - upd_ready=1.
    - On upd_valid&upd_ready:
      - If upd_setting >= NUM_RX_SETTINGS: set err_illegal, remain IDLE, no stall.
      - Else if upd_setting == rx_setting: pulse upd_done next cycle, no stall.
      - Else latch pending setting and go to STALL.
  - STALL:
    - upd_ready=0, stall_req=1.
    - Wait for stall_ack=1, then go to APPLY.
    - No timeout.
  - APPLY:
    - Drive rx_setting=pending for the one-cycle state.
    - Load settle counter with PWL_LATENCY-1.
    - Go to SETTLE.
  - SETTLE:
    - Decrement the counter each cycle.
    - At 0, go to RELEASE.
    - Total cycles from the APPLY edge to RELEASE entry = PWL_LATENCY.
  - RELEASE:
    - stall_req=0, upd_done=1 (one cycle).
    - Return to IDLE when stall_ack=0.
    - While stall_ack remains 1, stay in RELEASE with upd_done low after the first cycle.

- History counter:
  - Increments on each time_eq_in, saturating at NUM_UI.
  - Is not cleared by setting changes; history values stay valid and only the pulse tables change.

- out_valid:
  - Equals (hist_count==NUM_UI) && state ∈ {IDLE}.
  - Registered, so it drops one cycle after leaving IDLE and rises one cycle after returning.

- err_event:
  - Set when time_eq_in=1 && stall_ack=1.
  - The event is still counted in hist_count.
  - Cleared only by reset.

- Boundary conditions:
  - Simultaneous upd_valid and time_eq_in in IDLE: both honoured, no conflict.
  - stall_ack dropping during SETTLE: continue the sequence and set err_event.
  - Reset mid-sequence returns to DEFAULT_SETTING immediately (async) and drops stall_req.
  - PWL_LATENCY=1 is legal: SETTLE lasts one cycle.

Decomposition:
- filter_package holds:
  - NUM_UI, RX_SETTING_WIDTH, NUM_RX_SETTINGS, and the PWL_LATENCY constant.
  - The state enum typedef FILTER_CTRL_STATE.
  - The width constant HIST_COUNT_WIDTH.
- One natural sub-module: sat_counter (saturating up-counter with enable, async active-low reset), used for hist_count.
- The settle counter stays inline.

Test Plan:
- Reset release, 10 time_eq_in pulses (NUM_UI=8) → hist_count steps 1..8 and holds 8; out_valid=1 one cycle after the 8th pulse; rx_setting=0 throughout.
- upd_setting=5, stall_ack returns 3 cycles after stall_req:
  - rx_setting=5 one cycle after stall_ack seen.
  - stall_req low PWL_LATENCY+1 cycles later, with a single upd_done pulse.
  - out_valid low from STALL through RELEASE.
- upd_setting=13 (≥12) → err_illegal=1 sticky, stall_req never asserts, rx_setting unchanged, upd_ready stays 1.
- upd_setting equal to current rx_setting → upd_done pulse with no stall_req, out_valid uninterrupted.
- time_eq_in pulsed while stall_ack=1 in SETTLE → err_event=1, hist_count still increments (or holds at saturation), sequence completes normally.
- Assert rst low during SETTLE after an update to 7 → rx_setting=0, stall_req=0, hist_count=0 immediately; after release, upd_ready=1 and a new update to 3 completes normally.
